xbar_perm_loader: RTL and testbench

// Upstream config stage for the Benes crossbar: collects a SIZE-entry permutation, LANES tags per beat, over a

---
 rtl/xbar_perm_loader.sv | 154 +++++++++++++++
 tb/tb_xbar_perm_loader.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xbar_perm_loader.sv
// Permutation loader for the Benes crossbar: gathers SIZE tags over a beat stream,
// rejects any permutation with a repeated tag, and holds a good one until it is taken.
module xbar_perm_loader #(
    parameter  int SIZE     = 32,
    parameter  int LANES    = 4,
    localparam int TAGWIDTH = $clog2(SIZE)
) (
    input  logic                      clk,
    input  logic                      n_rst,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [LANES*TAGWIDTH-1:0] in_tags,
    output logic                      perm_valid,
    input  logic                      perm_ready,
    output logic [SIZE*TAGWIDTH-1:0]  perm,
    output logic                      err,
    output logic [TAGWIDTH-1:0]       err_tag
);

    // state   | meaning
    // COLLECT | accepting beats, building perm and the seen bitmap
    // HOLD    | verified perm presented, waiting for perm_ready

    localparam int TW    = TAGWIDTH;
    localparam int BEATS = SIZE / LANES;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic {COLLECT = 1'b0, HOLD = 1'b1} state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        beat_cnt_q, beat_cnt_d;
    logic [SIZE-1:0]      seen_q, seen_d;
    logic                 dup_q, dup_d;
    logic [TW-1:0]        dup_tag_q, dup_tag_d;
    logic [SIZE*TW-1:0]   perm_q, perm_d;
    logic                 err_q, err_d;
    logic [TW-1:0]        err_tag_q, err_tag_d;

    logic [TW-1:0]        lane_tag [LANES];
    logic                 accept;
    logic                 last_beat;
    logic                 beat_dup;
    logic [TW-1:0]        beat_dup_tag;
    logic                 hit;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= COLLECT;
            beat_cnt_q <= '0;
            seen_q     <= '0;
            dup_q      <= 1'b0;
            dup_tag_q  <= '0;
            perm_q     <= '0;
            err_q      <= 1'b0;
            err_tag_q  <= '0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            seen_q     <= seen_d;
            dup_q      <= dup_d;
            dup_tag_q  <= dup_tag_d;
            perm_q     <= perm_d;
            err_q      <= err_d;
            err_tag_q  <= err_tag_d;
        end
    end

    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            lane_tag[k] = in_tags[k*TW +: TW];
        end
    end

    // Scan lanes high to low so the lowest duplicated lane sets the tag last.
    always_comb begin
        beat_dup     = 1'b0;
        beat_dup_tag = '0;
        hit          = 1'b0;
        for (int k = LANES - 1; k >= 0; k--) begin
            hit = seen_q[lane_tag[k]];
            for (int j = 0; j < k; j++) begin
                if (lane_tag[j] == lane_tag[k]) hit = 1'b1;
            end
            if (hit) begin
                beat_dup     = 1'b1;
                beat_dup_tag = lane_tag[k];
            end
        end
    end

    assign accept    = in_valid & in_ready & ~flush;
    assign last_beat = (beat_cnt_q == CW'(BEATS - 1));

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = COLLECT;
        end else begin
            case (state_q)
                COLLECT: if (accept && last_beat && !(dup_q || beat_dup)) state_d = HOLD;
                HOLD:    if (perm_ready) state_d = COLLECT;
                default: state_d = COLLECT;
            endcase
        end
    end

    always_comb begin
        beat_cnt_d = beat_cnt_q;
        seen_d     = seen_q;
        dup_d      = dup_q;
        dup_tag_d  = dup_tag_q;
        perm_d     = perm_q;
        err_d      = 1'b0;
        err_tag_d  = err_tag_q;
        if (flush) begin
            beat_cnt_d = '0;
            seen_d     = '0;
            dup_d      = 1'b0;
        end else if (accept) begin
            for (int b = 0; b < BEATS; b++) begin
                if (beat_cnt_q == CW'(b)) perm_d[b*LANES*TW +: LANES*TW] = in_tags;
            end
            if (last_beat) begin
                beat_cnt_d = '0;
                seen_d     = '0;
                dup_d      = 1'b0;
                if (dup_q || beat_dup) begin
                    err_d     = 1'b1;
                    err_tag_d = dup_q ? dup_tag_q : beat_dup_tag;
                end
            end else begin
                beat_cnt_d = beat_cnt_q + CW'(1);
                for (int k = 0; k < LANES; k++) begin
                    seen_d[lane_tag[k]] = 1'b1;
                end
                if (!dup_q && beat_dup) begin
                    dup_d     = 1'b1;
                    dup_tag_d = beat_dup_tag;
                end
            end
        end
    end

    always_comb begin
        in_ready   = (state_q == COLLECT);
        perm_valid = (state_q == HOLD);
    end

    assign perm    = perm_q;
    assign err     = err_q;
    assign err_tag = err_tag_q;

endmodule

// File: tb/tb_xbar_perm_loader.sv
// Scoreboard bench for xbar_perm_loader: expected perms / err tags are queued when a
// permutation is driven and compared when the loader hands it off or pulses err.
module tb_xbar_perm_loader;

    localparam int SIZE  = 32;
    localparam int LANES = 4;
    localparam int TW    = 5;
    localparam int BEATS = SIZE / LANES;
    localparam int PW    = SIZE * TW;

    logic                 clk;
    logic                 n_rst;
    logic                 flush;
    logic                 in_valid;
    logic                 in_ready;
    logic [LANES*TW-1:0]  in_tags;
    logic                 perm_valid;
    logic                 perm_ready;
    logic [PW-1:0]        perm;
    logic                 err;
    logic [TW-1:0]        err_tag;

    xbar_perm_loader #(.SIZE(SIZE), .LANES(LANES)) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_tags    (in_tags),
        .perm_valid (perm_valid),
        .perm_ready (perm_ready),
        .perm       (perm),
        .err        (err),
        .err_tag    (err_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    logic [PW-1:0] exp_perm_q [$];
    int            exp_err_q  [$];

    int   hs_cnt   = 0;
    int   err_cnt  = 0;
    int   hs_edge  = 0;
    int   err_edge = 0;
    logic prev_err = 1'b0;

    always @(negedge clk) begin
        if (!n_rst) begin
            prev_err = 1'b0;
        end else begin
            if (perm_valid && perm_ready) begin
                hs_cnt++;
                hs_edge = cyc + 1;
                if (exp_perm_q.size() == 0) check("unexp_perm", 1, 0);
                else                        check("perm", perm, exp_perm_q.pop_front());
            end
            if (err) begin
                err_cnt++;
                err_edge = cyc;
                check("err_1cyc", prev_err, 0);
                if (exp_err_q.size() == 0) check("unexp_err", 1, 0);
                else                       check("err_tag", err_tag, exp_err_q.pop_front());
            end
            prev_err = err;
        end
    end

    logic [TW-1:0] cur [SIZE];

    function automatic logic [PW-1:0] pack_cur();
        logic [PW-1:0] r;
        for (int i = 0; i < SIZE; i++) r[i*TW +: TW] = cur[i];
        return r;
    endfunction

    // Reference: walk entries in stream order; the first value seen twice is the err tag.
    function automatic int first_dup();
        bit [SIZE-1:0] s = '0;
        for (int i = 0; i < SIZE; i++) begin
            if (s[cur[i]]) return int'(cur[i]);
            s[cur[i]] = 1'b1;
        end
        return -1;
    endfunction

    task automatic set_identity();
        for (int i = 0; i < SIZE; i++) cur[i] = TW'(i);
    endtask

    task automatic set_reverse();
        for (int i = 0; i < SIZE; i++) cur[i] = TW'(SIZE - 1 - i);
    endtask

    task automatic set_shuffle();
        logic [TW-1:0] t;
        int            j;
        set_identity();
        for (int i = SIZE - 1; i > 0; i--) begin
            j      = $urandom_range(i);
            t      = cur[i];
            cur[i] = cur[j];
            cur[j] = t;
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input int nb, input int gap, input bit push, output int acc0, output int accl);
        int d;
        int waited;
        bit r;
        acc0 = -1;
        accl = -1;
        if (push) begin
            d = first_dup();
            if (d < 0) exp_perm_q.push_back(pack_cur());
            else       exp_err_q.push_back(d);
        end
        for (int b = 0; b < nb; b++) begin
            for (int g = 0; g < 10 && gap > 0 && $urandom_range(99) < gap; g++) begin
                in_valid = 1'b0;
                in_tags  = (LANES*TW)'($urandom);
                tick(1);
            end
            in_valid = 1'b1;
            for (int k = 0; k < LANES; k++) in_tags[k*TW +: TW] = cur[b*LANES + k];
            waited = 0;
            r      = 1'b0;
            while (!r && waited < 200) begin
                @(negedge clk);
                r = in_ready;
                tick(1);
                waited++;
            end
            if (!r) begin
                check("acc_timeout", 0, 1);
                in_valid = 1'b0;
                return;
            end
            if (b == 0) acc0 = cyc;
            accl = cyc;
        end
        in_valid = 1'b0;
        in_tags  = (LANES*TW)'($urandom);
    endtask

    int a0, al, h0, e0, prev_l;

    initial begin
        n_rst      = 1'b0;
        flush      = 1'b0;
        in_valid   = 1'b0;
        in_tags    = '0;
        perm_ready = 1'b1;
        #12;
        check("rst_pv", perm_valid, 0);
        check("rst_err", err, 0);
        check("rst_err_tag", err_tag, 0);
        check("rst_perm", perm, 0);
        @(posedge clk); #1;
        n_rst = 1'b1;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        tick(1);

        // identity, back-to-back beats, consumer ready
        h0 = hs_cnt; e0 = err_cnt;
        set_identity();
        send(BEATS, 0, 1, a0, al);
        tick(3);
        check("id_beats", al - a0, BEATS - 1);
        check("id_hs_lat", hs_edge - a0, BEATS);
        check("id_hs_cnt", hs_cnt - h0, 1);
        check("id_no_err", err_cnt - e0, 0);

        // reversal held 20 cycles, then next perm waits for the handshake
        perm_ready = 1'b0;
        set_reverse();
        send(BEATS, 0, 1, a0, al);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("hold_pv", perm_valid, 1);
            check("hold_in_ready", in_ready, 0);
            check("hold_perm", perm, pack_cur());
        end
        @(posedge clk); #1;
        perm_ready = 1'b1;
        set_identity();
        send(BEATS, 0, 1, a0, al);
        check("no_bypass", a0, hs_edge + 1);
        tick(3);

        // cross-beat duplicate: entry 14 repeats entry 5
        h0 = hs_cnt; e0 = err_cnt;
        set_identity();
        cur[14] = 5;
        send(BEATS, 0, 1, a0, al);
        prev_l = al;
        set_shuffle();
        send(BEATS, 0, 1, a0, al);
        check("dup_err_edge", err_edge, prev_l);
        check("dup_restart", a0, prev_l + 1);
        tick(3);
        check("dup_err_cnt", err_cnt - e0, 1);
        check("dup_hs_cnt", hs_cnt - h0, 1);

        // intra-beat duplicate in beat 0
        set_identity();
        cur[0] = 7; cur[1] = 7; cur[2] = 1; cur[3] = 2;
        send(BEATS, 0, 1, a0, al);
        tick(2);

        // random perms (some corrupted) with input gaps
        for (int n = 0; n < 8; n++) begin
            set_shuffle();
            if (n % 3 == 2) cur[$urandom_range(SIZE-1)] = TW'($urandom);
            send(BEATS, 30, 1, a0, al);
        end
        tick(4);

        // flush after 5 beats, then a fresh identity
        h0 = hs_cnt; e0 = err_cnt;
        set_identity();
        send(5, 0, 0, a0, al);
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        send(BEATS, 0, 1, a0, al);
        tick(3);
        check("flush_hs_cnt", hs_cnt - h0, 1);
        check("flush_no_err", err_cnt - e0, 0);

        // flush coincident with a beat: that beat must not count
        set_reverse();
        send(3, 0, 0, a0, al);
        in_valid = 1'b1;
        for (int k = 0; k < LANES; k++) in_tags[k*TW +: TW] = cur[3*LANES + k];
        flush = 1'b1;
        tick(1);
        flush    = 1'b0;
        in_valid = 1'b0;
        send(BEATS, 0, 1, a0, al);
        tick(3);

        // flush while holding
        perm_ready = 1'b0;
        set_shuffle();
        send(BEATS, 0, 0, a0, al);
        @(negedge clk);
        check("fhold_pv", perm_valid, 1);
        @(posedge clk); #1;
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        @(negedge clk);
        check("fhold_pv_drop", perm_valid, 0);
        check("fhold_in_ready", in_ready, 1);
        tick(1);

        // async reset in HOLD
        set_shuffle();
        send(BEATS, 0, 0, a0, al);
        #3 n_rst = 1'b0;
        #1 check("arst_hold_pv", perm_valid, 0);
        tick(1);
        n_rst = 1'b1;
        // async reset during an err pulse
        perm_ready = 1'b1;
        set_identity();
        cur[31] = 0;
        send(BEATS, 0, 0, a0, al);
        check("err_before_rst", err, 1);
        #1 n_rst = 1'b0;
        #1 check("arst_err", err, 0);
        tick(1);
        n_rst = 1'b1;
        // async reset mid-collection, then a full fresh perm
        set_reverse();
        send(3, 0, 0, a0, al);
        #2 n_rst = 1'b0;
        #1 check("arst_mid_pv", perm_valid, 0);
        tick(1);
        n_rst = 1'b1;
        h0 = hs_cnt;
        set_shuffle();
        send(BEATS, 0, 1, a0, al);
        tick(5);
        check("arst_hs_cnt", hs_cnt - h0, 1);

        check("q_perm_empty", exp_perm_q.size(), 0);
        check("q_err_empty", exp_err_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
